// File: rtl/ysyx_23060203_pkg.sv
// Shared types for the IFU fetch queue: fetch buffer entry, fetch state encoding, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_23060203_pkg;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } fq_state_t;

  // Instructions are word aligned; low address bits of a redirect target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060203_fetch_fifo.sv
// Generic synchronous FIFO with registered storage and a synchronous flush.
// Latency: push -> o_empty deasserts next cycle; head is read straight from storage.
// Backpressure: push ignored when full unless a pop happens in the same cycle; flush beats push/pop.
// Ports: i_clk/i_rst (async active-high), i_push/i_push_dat, i_pop, i_flush, o_full, o_empty, o_head_dat.
module ysyx_23060203_fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_push_dat,
  input  logic i_pop,
  input  logic i_flush,
  output logic o_full,
  output logic o_empty,
  output T     o_head_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic w_push;
  logic w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rd_ptr];

  // Full-and-popping still accepts a push: the slot frees on the same edge.
  assign w_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_push = i_push & ~i_flush & (~o_full | w_pop);

  // DEPTH is a power of two, so plain pointer increment wraps correctly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/ysyx_23060203_fetch_queue.sv
// IFU front end: owns the fetch PC, presents it to the ICache, buffers hit {pc,inst} toward the IDU.
// Latency: ICache hit -> out_valid on the next cycle; one instruction per cycle sustained.
// Backpressure: out_ready low fills the buffer, after which the PC holds until an entry is popped.
// Ports: clock/reset (async active-high); redirect_valid/pc/fencei from EXU/WBU; icache_addr,
//   icache_hit, icache_inst, flush_icache to/from ICache; out_valid/ready/pc/inst toward IDU.
module ysyx_23060203_fetch_queue #(
  parameter logic [31:0] RESET_PC   = ysyx_23060203_pkg::RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_fencei,
  output logic [31:0] icache_addr,
  input  logic        icache_hit,
  input  logic [31:0] icache_inst,
  output logic        flush_icache,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  import ysyx_23060203_pkg::*;

  fq_state_t    r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend_pc;
  logic         r_pend_fencei;
  logic         r_flush;

  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  fetch_entry_t w_push_dat;
  fetch_entry_t w_head;
  logic [31:0]  w_sel_pc;
  logic         w_sel_fencei;

  assign w_pop = ~w_empty & out_ready;

  // Fetching is allowed in RUN and on the cycle a MISS resolves. A hit seen during the ICache
  // flush cycle may belong to the old contents, and a redirect kills the current PC's fetch.
  assign w_push = (r_state != DRAIN) & icache_hit & ~r_flush & ~redirect_valid
                & (~w_full | w_pop);

  assign w_push_dat.pc   = r_pc;
  assign w_push_dat.inst = icache_inst;

  // A redirect arriving in the same cycle the drain completes is the youngest and wins.
  assign w_sel_pc     = redirect_valid ? align_pc(redirect_pc) : r_pend_pc;
  assign w_sel_fencei = redirect_valid ? redirect_fencei       : r_pend_fencei;

  ysyx_23060203_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head)
  );

  // The PC only moves on a push or a redirect apply; while a refill is outstanding (MISS/DRAIN)
  // it must stay put because the ICache keys the refill on icache_addr.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_pend_pc     <= '0;
      r_pend_fencei <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        RUN: begin
          if (redirect_valid) begin
            if (icache_hit) begin
              r_pc    <= align_pc(redirect_pc);
              r_flush <= redirect_fencei;
            end else begin
              r_pend_pc     <= align_pc(redirect_pc);
              r_pend_fencei <= redirect_fencei;
              r_state       <= DRAIN;
            end
          end else if (!icache_hit) begin
            r_state <= MISS;
          end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        MISS: begin
          if (redirect_valid) begin
            r_pend_pc     <= align_pc(redirect_pc);
            r_pend_fencei <= redirect_fencei;
            r_state       <= DRAIN;
          end else if (icache_hit) begin
            r_state <= RUN;
            if (w_push) r_pc <= r_pc + 32'd4;
          end
        end
        DRAIN: begin
          if (icache_hit) begin
            r_pc    <= w_sel_pc;
            r_flush <= w_sel_fencei;
            r_state <= RUN;
          end else if (redirect_valid) begin
            r_pend_pc     <= align_pc(redirect_pc);
            r_pend_fencei <= redirect_fencei;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign icache_addr  = r_pc;
  assign flush_icache = r_flush;
  assign out_valid    = ~w_empty;
  assign out_pc       = w_head.pc;
  assign out_inst     = w_head.inst;

endmodule

// File: tb/tb_ysyx_23060203_fetch_queue.sv
module tb_ysyx_23060203_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_fencei;
  logic [31:0] icache_addr;
  logic        icache_hit;
  logic [31:0] icache_inst;
  logic        flush_icache;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] sb[$];
  logic [31:0] exp_pc;

  always #5 clock = ~clock;

  ysyx_23060203_fetch_queue #(
    .RESET_PC   (32'h3000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_fencei (redirect_fencei),
    .icache_addr     (icache_addr),
    .icache_hit      (icache_hit),
    .icache_inst     (icache_inst),
    .flush_icache    (flush_icache),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic hit_cycle(input bit exp_push);
    icache_hit  = 1'b1;
    icache_inst = inst_of(exp_pc);
    chk("icache_addr", 64'(icache_addr), 64'(exp_pc));
    if (exp_push) begin
      sb.push_back({exp_pc, icache_inst});
      exp_pc = exp_pc + 32'd4;
    end
    cyc();
  endtask

  task automatic miss_cycle();
    icache_hit  = 1'b0;
    icache_inst = 32'hDEAD_BEEF;
    chk("icache_addr_hold", 64'(icache_addr), 64'(exp_pc));
    cyc();
  endtask

  // Redirect for one cycle; the FIFO is emptied on that edge, so nothing queued is expected any more.
  task automatic redirect(input logic [31:0] pc, input bit fencei, input bit hit);
    redirect_valid  = 1'b1;
    redirect_pc     = pc;
    redirect_fencei = fencei;
    icache_hit      = hit;
    icache_inst     = inst_of(exp_pc);
    chk("icache_addr_redir", 64'(icache_addr), 64'(exp_pc));
    sb.delete();
    cyc();
    redirect_valid  = 1'b0;
    redirect_fencei = 1'b0;
  endtask

  // Monitor: every accepted head entry must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: got pc=%h inst=%h, expected no entry", out_pc, out_inst);
      end else begin
        chk("out_entry", {out_pc, out_inst}, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    redirect_fencei = 1'b0;
    icache_hit      = 1'b0;
    icache_inst     = '0;
    out_ready       = 1'b0;
    #2;
    chk("rst_addr",  64'(icache_addr),  64'h3000_0000);
    chk("rst_valid", 64'(out_valid),    64'h0);
    chk("rst_flush", 64'(flush_icache), 64'h0);
    #20;
    reset  = 1'b0;
    exp_pc = 32'h3000_0000;

    // Streaming hits A,B,C with the IDU always ready.
    out_ready = 1'b1;
    hit_cycle(1'b1);
    chk("first_valid", 64'(out_valid), 64'h1);
    hit_cycle(1'b1);
    hit_cycle(1'b1);
    repeat (3) miss_cycle();
    chk("drained_t1", 64'(sb.size()), 64'h0);

    // Fill under backpressure, PC holds while full, resume with pop+push per cycle.
    out_ready = 1'b0;
    repeat (4) hit_cycle(1'b1);
    repeat (3) hit_cycle(1'b0);
    chk("full_addr", 64'(icache_addr), 64'h3000_001C);
    chk("full_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    repeat (3) hit_cycle(1'b1);
    repeat (5) miss_cycle();
    chk("drained_t2", 64'(sb.size()), 64'h0);

    // Redirect during a miss waits for the refill to finish before moving the PC.
    repeat (2) miss_cycle();
    redirect(32'h8000_0003, 1'b0, 1'b0);
    repeat (7) miss_cycle();
    hit_cycle(1'b0);
    exp_pc = 32'h8000_0000;
    chk("redir_addr", 64'(icache_addr), 64'h8000_0000);
    chk("redir_empty", 64'(out_valid), 64'h0);

    // fence.i redirect while hitting: one flush pulse, no push during it; a second fence.i
    // issued in the flush cycle gives a second pulse.
    hit_cycle(1'b1);
    hit_cycle(1'b1);
    redirect(32'h3000_0100, 1'b1, 1'b1);
    exp_pc = 32'h3000_0100;
    chk("fencei_pulse", 64'(flush_icache), 64'h1);
    chk("fencei_empty", 64'(out_valid), 64'h0);
    hit_cycle(1'b0);
    chk("fencei_pulse_end", 64'(flush_icache), 64'h0);
    chk("fencei_no_push", 64'(out_valid), 64'h0);
    hit_cycle(1'b1);
    redirect(32'h3000_0200, 1'b1, 1'b1);
    exp_pc = 32'h3000_0200;
    chk("fencei2_pulse", 64'(flush_icache), 64'h1);
    redirect(32'h3000_0300, 1'b1, 1'b1);
    exp_pc = 32'h3000_0300;
    chk("fencei3_pulse", 64'(flush_icache), 64'h1);
    hit_cycle(1'b0);
    chk("fencei3_pulse_end", 64'(flush_icache), 64'h0);
    hit_cycle(1'b1);

    // Two redirects while draining: only the youngest target is fetched.
    miss_cycle();
    redirect(32'h8000_0000, 1'b0, 1'b0);
    redirect(32'h9000_0000, 1'b0, 1'b0);
    miss_cycle();
    hit_cycle(1'b0);
    exp_pc = 32'h9000_0000;
    chk("drain_youngest", 64'(icache_addr), 64'h9000_0000);
    chk("drain_no_flush", 64'(flush_icache), 64'h0);
    hit_cycle(1'b1);
    hit_cycle(1'b1);
    repeat (3) miss_cycle();
    chk("drained_t5", 64'(sb.size()), 64'h0);

    // Asynchronous reset in the middle of a miss with a buffered entry.
    out_ready = 1'b0;
    icache_hit = 1'b1;
    hit_cycle(1'b1);
    repeat (2) miss_cycle();
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid),    64'h0);
    chk("async_rst_addr",  64'(icache_addr),  64'h3000_0000);
    chk("async_rst_flush", 64'(flush_icache), 64'h0);
    sb.delete();
    #10;
    reset     = 1'b0;
    exp_pc    = 32'h3000_0000;
    out_ready = 1'b1;
    cyc();
    chk("post_rst_addr", 64'(icache_addr), 64'h3000_0000);
    hit_cycle(1'b1);
    repeat (3) miss_cycle();
    chk("drained_final", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
